dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
Initiator-side controller that drives the data-memory port (isVector/we/address/wd/rd) on behalf of the pipeline MEM stage.
- Accepts one scalar or vector load/store request at a time over a valid/ready handshake.
- Sequences the memory read latency and performs read-modify-write for lane-masked vector stores.
- Returns load data or a store acknowledgement over a second valid/ready handshake.

Parameters:
LANES, 6, number of 32-bit lanes in a vector word
LANE_W, 32, lane width in bits (vector width VEC_W = LANES*LANE_W = 192)
RD_LAT, 1, clock edges from memAddress registered to memRd valid (>=1)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous active-high reset
reqValid  in  1  request present
reqReady  out  1  controller can accept; high only in IDLE
reqWrite  in  1  1=store, 0=load
reqIsVector  in  1  1=192-bit vector access, 0=32-bit scalar
reqAddress  in  32  memory address, passed unchanged to memory
reqData  in  VEC_W  store data; scalar uses [31:0]
reqMask  in  LANES  vector store lane enables; ignored for loads and scalar
respValid  out  1  response present
respReady  in  1  consumer accepts response
respData  out  VEC_W  load data; 0 for store acks
busy  out  1  state != IDLE
memIsVector  out  1  to dmem_ram isVector
memWe  out  1  to dmem_ram we
memAddress  out  32  to dmem_ram address
memWd  out  VEC_W  to dmem_ram wd
memRd  in  VEC_W  from dmem_ram rd

Behaviour:
- Reset (synchronous, active-high; also mid-operation):
  - State goes to IDLE and any in-flight request and pending response are discarded.
  - respValid=0, respData=0, memWe=0, memIsVector=0, memAddress=0, memWd=0.
  - memWe must be low in the cycle after a reset edge.
- States: IDLE, LD_WAIT, ST_WR, RMW_WAIT, RMW_WR, RESP.
- One outstanding request; reqReady = (state==IDLE). A request is accepted on the edge where reqValid&&reqReady (edge E0); reqAddress/reqIsVector are registered onto memAddress/memIsVector at E0.
- Load, IDLE->LD_WAIT:
  - memWe=0; wait RD_LAT edges.
  - At edge E0+RD_LAT capture memRd into respData: vector = full 192 bits; scalar = {160'b0, memRd[31:0]}.
  - Set respValid; go to RESP.
  - RD_LAT=1: respValid visible in the cycle after E1.
- Store, scalar or vector with reqMask all ones, IDLE->ST_WR:
  - memWe=1 for exactly one cycle (E0..E1); memWd = reqData (scalar: {160'b0, reqData[31:0]}).
  - At E1 memWe=0, respValid=1, respData=0; go to RESP.
- Vector store with partial mask, IDLE->RMW_WAIT:
  - Read phase with memWe=0 for RD_LAT edges.
  - At E0+RD_LAT form memWd lane-by-lane: lane i (bits 32i+31:32i) = reqMask[i] ? reqData lane : memRd lane. Assert memWe; go to RMW_WR.
  - At the next edge drop memWe, set respValid; go to RESP.
  - Address is held constant across both phases.
- Vector store with reqMask = 0: no memory write at all (memWe never asserted); ack after one cycle as in ST_WR.
- RESP:
  - respValid and respData are held stable until respValid&&respReady.
  - On that edge respValid=0 and state returns to IDLE; reqReady rises the following cycle.
  - No bypass: at least one idle cycle between back-to-back requests.
- memAddress/memIsVector hold their last value in IDLE; memWe is 0 in every state except ST_WR and RMW_WR.
- reqValid while not ready is ignored; no request fields are sampled outside the accept edge.

Decomposition:
- Package dmem_pkg: LANES, LANE_W, VEC_W constants; state_t enum; lane-slice helper function.
- Sub-module dmem_lane_merge: combinational merge of old/new vector words under mask; instantiated once.
- FSM and registers stay in dmem_access_ctrl.

Test Plan:
- Scalar store reqAddress=0, reqData=33 -> memWe=1 for exactly 1 cycle, memWd=33, memIsVector=0; ack respValid with respData=0.
- Vector store addr=2, data=64'd123456789112, mask=6'b111111, then vector load addr=2 against a dmem_ram model -> load respData=64'd123456789112 zero-extended to 192 bits, returned RD_LAT+1 cycles after accept.
- Masked store mask=6'b000101 over memory word of all 0xAAAAAAAA lanes with new lanes 0x11111111 -> lanes 0,2 = 0x11111111, others 0xAAAAAAAA; exactly one read phase then one memWe pulse.
- Load with respReady held low for 5 cycles -> respValid/respData stable for all 5 cycles, reqReady=0 throughout, then IDLE one cycle after handshake.
- Reset asserted during RMW_WAIT -> no memWe pulse afterwards, respValid=0, reqReady=1 in cycle after reset deasserts.
- Vector store mask=0 -> memWe never asserted, ack still returned after one cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants, FSM encoding and lane helpers for the data-memory access controller.
package dmem_pkg;
  localparam int LANES  = 6;
  localparam int LANE_W = 32;
  localparam int VEC_W  = LANES * LANE_W;

  typedef enum logic [2:0] {
    IDLE, LD_WAIT, ST_WR, RMW_WAIT, RMW_WR, RESP
  } state_t;

  // Request fields still needed after the accept edge.
  typedef struct packed {
    logic              is_vec;
    logic [LANES-1:0]  mask;
    logic [VEC_W-1:0]  data;
  } req_t;

  function automatic logic [LANE_W-1:0] lane_slice(input logic [VEC_W-1:0] v, input int unsigned i);
    return v[i*LANE_W +: LANE_W];
  endfunction

  function automatic logic [VEC_W-1:0] zext_scalar(input logic [LANE_W-1:0] x);
    return {{(VEC_W-LANE_W){1'b0}}, x};
  endfunction
endpackage

// File: rtl/dmem_lane_merge.sv
// Combinational lane-wise merge of the old memory word with new store data under a lane mask.
module dmem_lane_mux
  import dmem_pkg::*;
(
  input  logic [LANE_W-1:0] old_lane,
  input  logic [LANE_W-1:0] new_lane,
  input  logic              sel,
  output logic [LANE_W-1:0] lane
);
  assign lane = sel ? new_lane : old_lane;
endmodule

module dmem_lane_merge
  import dmem_pkg::*;
(
  input  logic [VEC_W-1:0] old_word,
  input  logic [VEC_W-1:0] new_word,
  input  logic [LANES-1:0] mask,
  output logic [VEC_W-1:0] merged
);
  logic [LANES-1:0][LANE_W-1:0] merged_l;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dmem_lane_mux u_mux (
      .old_lane (lane_slice(old_word, i)),
      .new_lane (lane_slice(new_word, i)),
      .sel      (mask[i]),
      .lane     (merged_l[i])
    );
  end

  assign merged = merged_l;
endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage initiator for the data memory: one request at a time, read latency
// sequencing, read-modify-write for partially masked vector stores.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic              reqIsVector,
  input  logic [31:0]       reqAddress,
  input  logic [VEC_W-1:0]  reqData,
  input  logic [LANES-1:0]  reqMask,
  output logic              respValid,
  input  logic              respReady,
  output logic [VEC_W-1:0]  respData,
  output logic              busy,
  output logic              memIsVector,
  output logic              memWe,
  output logic [31:0]       memAddress,
  output logic [VEC_W-1:0]  memWd,
  input  logic [VEC_W-1:0]  memRd
);
  state_t            state, state_nxt;
  req_t              req;
  logic [RD_LAT-1:0] lat_pipe;
  logic              lat_done;
  logic              wr_en;
  logic              accept;
  logic              is_rmw;
  logic [31:0]       mem_addr;
  logic              mem_isvec;
  logic [VEC_W-1:0]  mem_wd;
  logic [VEC_W-1:0]  resp_data;
  logic [VEC_W-1:0]  merged;

  assign accept   = reqValid && reqReady;
  assign lat_done = lat_pipe[RD_LAT-1];
  assign is_rmw   = reqIsVector && (reqMask != '0) && (reqMask != '1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (reqValid) state_nxt = !reqWrite ? LD_WAIT : (is_rmw ? RMW_WAIT : ST_WR);
      LD_WAIT:  if (lat_done) state_nxt = RESP;
      ST_WR:    state_nxt = RESP;
      RMW_WAIT: if (lat_done) state_nxt = RMW_WR;
      RMW_WR:   state_nxt = RESP;
      RESP:     if (respReady) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // A mask-zero vector store rides ST_WR for its one-cycle ack but never strobes memWe.
  always_comb begin
    reqReady  = (state == IDLE);
    busy      = (state != IDLE);
    respValid = (state == RESP);
    memWe     = ((state == ST_WR) && wr_en) || (state == RMW_WR);
  end

  dmem_lane_merge u_merge (
    .old_word (memRd),
    .new_word (req.data),
    .mask     (req.mask),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_isvec <= 1'b0;
      mem_wd    <= '0;
      resp_data <= '0;
      lat_pipe  <= '0;
      wr_en     <= 1'b0;
      req       <= '0;
    end else begin
      lat_pipe <= lat_pipe << 1;
      if (accept) begin
        mem_addr  <= reqAddress;
        mem_isvec <= reqIsVector;
        req       <= '{is_vec: reqIsVector, mask: reqMask, data: reqData};
        lat_pipe  <= RD_LAT'(1);
        wr_en     <= !(reqIsVector && (reqMask == '0));
        if (reqWrite) mem_wd <= reqIsVector ? reqData : zext_scalar(reqData[LANE_W-1:0]);
      end
      case (state)
        LD_WAIT:       if (lat_done) resp_data <= req.is_vec ? memRd : zext_scalar(memRd[LANE_W-1:0]);
        RMW_WAIT:      if (lat_done) mem_wd <= merged;
        ST_WR, RMW_WR: resp_data <= '0;
        default: ;
      endcase
    end
  end

  assign memAddress  = mem_addr;
  assign memIsVector = mem_isvec;
  assign memWd       = mem_wd;
  assign respData    = resp_data;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl against a small combinational-read memory model.
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             reqValid = 1'b0, reqWrite = 1'b0, reqIsVector = 1'b0;
  logic [31:0]      reqAddress = '0;
  logic [VEC_W-1:0] reqData = '0;
  logic [LANES-1:0] reqMask = '0;
  logic             respReady = 1'b1;
  logic             reqReady, respValid, busy, memIsVector, memWe;
  logic [VEC_W-1:0] respData, memWd, memRd;
  logic [31:0]      memAddress;
  logic             mem_init = 1'b1;

  typedef struct packed {
    logic [31:0]      a;
    logic             v;
    logic [VEC_W-1:0] d;
  } wr_t;

  logic [VEC_W-1:0] resp_q[$];
  wr_t              wr_q[$];
  logic [VEC_W-1:0] mem [0:15];
  int checks = 0, errors = 0;

  localparam logic [VEC_W-1:0] PAT_A   = {6{32'hAAAAAAAA}};
  localparam logic [VEC_W-1:0] PAT_7   = {6{32'h5A5A0F0F}};
  localparam logic [VEC_W-1:0] NEW_1   = {6{32'h11111111}};
  localparam logic [VEC_W-1:0] MERGED  =
    192'hAAAAAAAA_AAAAAAAA_AAAAAAAA_11111111_AAAAAAAA_11111111;
  localparam logic [VEC_W-1:0] VEC_D   = 192'd123456789112;

  dmem_access_ctrl #(.RD_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqIsVector(reqIsVector), .reqAddress(reqAddress), .reqData(reqData), .reqMask(reqMask),
    .respValid(respValid), .respReady(respReady), .respData(respData), .busy(busy),
    .memIsVector(memIsVector), .memWe(memWe), .memAddress(memAddress), .memWd(memWd), .memRd(memRd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem[5] <= PAT_A;
      mem[7] <= PAT_7;
    end else if (memWe) begin
      mem[memAddress[3:0]] <= memWd;
    end
  end
  assign memRd = mem[memAddress[3:0]];

  task automatic chk(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Response monitor: a handshake seen at the negedge completes at the next posedge.
  always @(negedge clk) begin
    if (!reset && respValid && respReady) begin
      if (resp_q.size() == 0) chk("resp_unexpected", 1, 0);
      else chk("resp_data", respData, resp_q.pop_front());
    end
  end

  // Write monitor: every memWe cycle must match exactly one expected write.
  always @(negedge clk) begin
    if (memWe) begin
      if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        wr_t w;
        w = wr_q.pop_front();
        chk("wr_addr", {160'b0, memAddress}, {160'b0, w.a});
        chk("wr_isvec", {191'b0, memIsVector}, {191'b0, w.v});
        chk("wr_data", memWd, w.d);
      end
    end
  end

  task automatic issue(input logic wr, input logic vec, input logic [31:0] a,
                       input logic [VEC_W-1:0] d, input logic [LANES-1:0] m);
    int n = 0;
    while (!reqReady && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready_wait", {191'b0, reqReady}, 1);
    reqValid = 1'b1; reqWrite = wr; reqIsVector = vec; reqAddress = a; reqData = d; reqMask = m;
    @(posedge clk); #1;
    reqValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((!reqReady || resp_q.size() != 0) && n < 200) begin
      @(negedge clk); n++;
    end
    chk("idle_wait", {191'b0, reqReady}, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; mem_init = 1'b0;
    @(negedge clk);
    chk("rst_reqReady",  {191'b0, reqReady}, 1);
    chk("rst_respValid", {191'b0, respValid}, 0);
    chk("rst_memWe",     {191'b0, memWe}, 0);
    chk("rst_busy",      {191'b0, busy}, 0);
    chk("rst_memIsVec",  {191'b0, memIsVector}, 0);
    chk("rst_memAddr",   {160'b0, memAddress}, 0);
    chk("rst_memWd",     memWd, 0);
    chk("rst_respData",  respData, 0);
    @(posedge clk); #1;

    // Scalar store: upper data bits must not reach memory
    wr_q.push_back('{a: 32'd0, v: 1'b0, d: 192'd33});
    resp_q.push_back('0);
    issue(1, 0, 32'd0, {{160{1'b1}}, 32'd33}, '0);
    wait_idle();

    // Full-mask vector store, then vector load with latency check
    wr_q.push_back('{a: 32'd2, v: 1'b1, d: VEC_D});
    resp_q.push_back('0);
    issue(1, 1, 32'd2, VEC_D, 6'b111111);
    wait_idle();
    resp_q.push_back(VEC_D);
    issue(0, 1, 32'd2, '0, '0);
    @(negedge clk); chk("ld_lat_early", {191'b0, respValid}, 0);
    @(negedge clk); chk("ld_lat",       {191'b0, respValid}, 1);
    wait_idle();

    // Partial-mask vector store: one read cycle, then one write pulse
    wr_q.push_back('{a: 32'd5, v: 1'b1, d: MERGED});
    resp_q.push_back('0);
    issue(1, 1, 32'd5, NEW_1, 6'b000101);
    @(negedge clk);
    chk("rmw_read_phase", {191'b0, memWe}, 0);
    chk("rmw_busy",       {191'b0, busy}, 1);
    wait_idle();
    resp_q.push_back(MERGED);
    issue(0, 1, 32'd5, '0, '0);
    wait_idle();

    // Stalled consumer: response held, stray request ignored
    respReady = 1'b0;
    resp_q.push_back(192'd33);
    issue(0, 0, 32'd0, '0, '0);
    begin
      int n = 0;
      while (!respValid && n < 50) begin @(negedge clk); n++; end
    end
    reqValid = 1'b1; reqWrite = 1'b1; reqIsVector = 1'b0; reqAddress = 32'd9; reqData = 192'd77;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_respValid", {191'b0, respValid}, 1);
      chk("hold_respData",  respData, 192'd33);
      chk("hold_reqReady",  {191'b0, reqReady}, 0);
    end
    @(posedge clk); #1;
    reqValid = 1'b0; respReady = 1'b1;
    @(negedge clk); chk("hs_pending_reqReady", {191'b0, reqReady}, 0);
    @(negedge clk); chk("idle_after_hs",       {191'b0, reqReady}, 1);
    @(posedge clk); #1;

    // Reset while waiting on the RMW read
    issue(1, 1, 32'd5, {6{32'h22222222}}, 6'b010000);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rstmid_reqReady",  {191'b0, reqReady}, 1);
    chk("rstmid_respValid", {191'b0, respValid}, 0);
    chk("rstmid_memWe",     {191'b0, memWe}, 0);
    chk("rstmid_memAddr",   {160'b0, memAddress}, 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    resp_q.push_back(MERGED);
    issue(0, 1, 32'd5, '0, '0);
    wait_idle();

    // Mask-zero vector store: ack after one cycle, memory untouched
    resp_q.push_back('0);
    issue(1, 1, 32'd7, NEW_1, 6'b000000);
    @(negedge clk); chk("mask0_early", {191'b0, respValid}, 0);
    @(negedge clk); chk("mask0_ack",   {191'b0, respValid}, 1);
    wait_idle();
    resp_q.push_back(PAT_7);
    issue(0, 1, 32'd7, '0, '0);
    wait_idle();

    repeat (4) @(negedge clk);
    chk("resp_q_empty", resp_q.size(), 0);
    chk("wr_q_empty",   wr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running req=finished");
    $fatal(1);
  end
endmodule
